compound_sink: RTL
==================

COMPOUND_SINK -- requirements
Module: compound_sink

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low; sampled only at rising clk edge.
REQ-003 b_in  in  CompoundType  data offered by upstream producer; fields mode (read/write), x (32-bit signed), y (bool).
REQ-004 b_in_sync  in  1  upstream has valid b_in this cycle.
REQ-005 b_in_notify  out  1  this block ready to accept b_in; transfer occurs when b_in_sync and b_in_notify are both 1 at the same edge.
REQ-006 r_out  out  32 signed  accumulated result snapshot.
REQ-007 r_out_count  out  8  number of write transfers folded into r_out.
REQ-008 r_out_sync  in  1  downstream accepts r_out this cycle.
REQ-009 r_out_notify  out  1  r_out/r_out_count valid; result transfer occurs when r_out_notify and r_out_sync are both 1.
REQ-010 m_out  out  32 signed  shared, non-blocking view of the live accumulator, registered.

Function
REQ-011 Two states, Sections enum: section_a (collect), section_b (emit); all outputs registered.
REQ-012 section_a: b_in_notify=1, r_out_notify=0.
REQ-013 section_a, transfer with mode=write: acc <= acc + x if y=1, acc - x if y=0; cnt <= cnt+1, saturating at 255; remain in section_a.
REQ-014 section_a, transfer with mode=read: r_out <= acc, r_out_count <= cnt, acc <= 0, cnt <= 0; next edge state section_b, b_in_notify=0, r_out_notify=1.
REQ-015 Latency: read transfer at edge N gives r_out_notify=1 after edge N; b_in_notify=0 from the same edge.
REQ-016 section_b: r_out, r_out_count held stable; b_in_sync ignored; no accumulation.
REQ-017 section_b with r_out_sync=1: r_out_notify <= 0, b_in_notify <= 1, state <= section_a; new input accepted from the following edge.
REQ-018 r_out_sync while r_out_notify=0 has no effect; b_in_sync while b_in_notify=0 has no effect.
REQ-019 Arithmetic is 32-bit two's complement, wrap-around modulo 2^32 unless REQ-024 applies.
REQ-020 m_out equals acc as registered at the previous edge, including the clear to 0 on read.

Reset
REQ-021 rst=0 at an edge: state=section_a, acc=0, cnt=0, r_out=0, r_out_count=0, m_out=0, r_out_notify=0, b_in_notify=1.
REQ-022 Reset during section_b discards the pending result; no r_out transfer completes.
REQ-023 rst has priority over every handshake event in the same cycle.

Configuration
REQ-024 COMPOUND_SINK_SAT_EN defined: add/subtract saturates to 32'h7FFFFFFF / 32'h80000000. Undefined: wrap per REQ-019.

Structure
REQ-025 CompoundType and the mode enum (read, write) are taken from the existing shared types package; the Sections enum (section_a, section_b) and the saturation limits go in a new package compound_sink_types.
REQ-026 A single sub-module, compound_sink_alu, is permitted: combinational signed add/sub with optional saturation; the FSM stays in compound_sink.

Verification
REQ-027 Reset, then writes (x=5,y=1),(x=3,y=0),(x=10,y=1), then read -> r_out=12, r_out_count=3, r_out_notify=1 one edge after the read; m_out=0 after the read.
REQ-028 Enter section_b, hold r_out_sync=0 for 4 cycles with b_in_sync=1 -> r_out and acc unchanged, b_in_notify=0; then r_out_sync=1 -> b_in_notify=1 on the next edge.
REQ-029 Write x=32'h7FFFFFFF,y=1, then x=1,y=1, then read -> r_out=32'h80000000 without the macro, 32'h7FFFFFFF with COMPOUND_SINK_SAT_EN.
REQ-030 300 consecutive writes (x=1,y=1), then read -> r_out=300, r_out_count=255.
REQ-031 rst=0 asserted while r_out_notify=1 -> after that edge r_out_notify=0, b_in_notify=1, a following read returns r_out=0 and r_out_count=0.
REQ-032 Read with no prior writes -> r_out=0, r_out_count=0, normal section_b handshake.

Source files
------------

// File: rtl/compound_sink_types.sv
// Types and constants that are local to compound_sink.
//
// Sections : FSM states. section_a collects writes. section_b holds a result
//            until the downstream consumer accepts it.
// SAT_MAX / SAT_MIN : accumulator clamp limits. They are only used when
//            COMPOUND_SINK_SAT_EN is defined.
package compound_sink_types;

    typedef enum logic {
        section_a = 1'b0,
        section_b = 1'b1
    } Sections;

    localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/shared_types.sv
// Shared types package used across the codebase.
//
// Provides the transaction mode enum and CompoundType. CompoundType is the
// record that a producer hands to a sink. Its fields are:
//   mode : read or write
//   x    : 32-bit signed operand
//   y    : bool. For a write, 1 selects add and 0 selects subtract.
package shared_types;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e              mode;
        logic signed [31:0] x;
        logic               y;
    } CompoundType;

endpackage

// File: rtl/compound_sink_alu.sv
// compound_sink_alu: a combinational 32-bit signed add/subtract.
//
// Ports:
//   a      in  32 signed  current accumulator
//   b      in  32 signed  operand
//   sub    in  1          1 gives a - b, 0 gives a + b
//   result out 32 signed  sum or difference
//
// Build option COMPOUND_SINK_SAT_EN: when it is defined, the result clamps to
// SAT_MAX/SAT_MIN on overflow. When it is undefined, the result wraps modulo
// 2^32.
module compound_sink_alu
    import compound_sink_types::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    input  logic               sub,
    output logic signed [31:0] result
);

`ifdef COMPOUND_SINK_SAT_EN
    logic signed [32:0] wide;

    // Sign-extend by one bit. Overflow has happened when the top two bits of
    // the wide result differ. The top bit then gives the true sign, which
    // picks the limit to clamp to.
    always_comb begin
        wide = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
        if (wide[32] != wide[31]) begin
            result = wide[32] ? SAT_MIN : SAT_MAX;
        end else begin
            result = wide[31:0];
        end
    end
`else
    always_comb begin
        result = sub ? (a - b) : (a + b);
    end
`endif

endmodule

// File: rtl/compound_sink.sv
// compound_sink: accumulates write transactions and emits the total when a
// read transaction arrives.
//
// Ports:
//   clk          in   1          clock. All state updates on the rising edge.
//   rst          in   1          synchronous reset, active low
//   b_in         in   CompoundType  upstream data {mode, x, y}
//   b_in_sync    in   1          upstream valid
//   b_in_notify  out  1          ready for b_in. High while collecting.
//   r_out        out  32 signed  result snapshot taken at a read
//   r_out_count  out  8          number of writes in r_out. Saturates at 255.
//   r_out_sync   in   1          downstream accepts the result
//   r_out_notify out  1          result valid
//   m_out        out  32 signed  registered live view of the accumulator
//
// Build option COMPOUND_SINK_SAT_EN makes the accumulator saturate instead of
// wrapping.
module compound_sink
    import shared_types::*;
    import compound_sink_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  CompoundType        b_in,
    input  logic               b_in_sync,
    output logic               b_in_notify,
    output logic signed [31:0] r_out,
    output logic [7:0]         r_out_count,
    input  logic               r_out_sync,
    output logic               r_out_notify,
    output logic signed [31:0] m_out
);

    Sections            state;
    logic signed [31:0] acc;
    logic [7:0]         cnt;
    logic signed [31:0] alu_result;

    compound_sink_alu u_alu (
        .a      (acc),
        .b      ($signed(b_in.x)),
        .sub    (~b_in.y),
        .result (alu_result)
    );

    // m_out is written every time acc is written, with the same value.
    // The external view therefore always matches the accumulator as it was
    // registered at the most recent edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= section_a;
            acc          <= '0;
            cnt          <= '0;
            r_out        <= '0;
            r_out_count  <= '0;
            m_out        <= '0;
            r_out_notify <= 1'b0;
            b_in_notify  <= 1'b1;
        end else begin
            case (state)
                section_a: begin
                    if (b_in_sync) begin
                        if (b_in.mode == write) begin
                            acc   <= alu_result;
                            m_out <= alu_result;
                            if (cnt != 8'hFF) begin
                                cnt <= cnt + 8'd1;
                            end
                        end else begin
                            r_out        <= acc;
                            r_out_count  <= cnt;
                            acc          <= '0;
                            cnt          <= '0;
                            m_out        <= '0;
                            b_in_notify  <= 1'b0;
                            r_out_notify <= 1'b1;
                            state        <= section_b;
                        end
                    end
                end
                section_b: begin
                    if (r_out_sync) begin
                        r_out_notify <= 1'b0;
                        b_in_notify  <= 1'b1;
                        state        <= section_a;
                    end
                end
                default: begin
                    state <= section_a;
                end
            endcase
        end
    end

endmodule
